sprite_pixel_gen: RTL and testbench
===================================

// Module: sprite_pixel_gen
// PURPOSE
//   Per-sprite pixel source that drives one sprite's on-flag and 24-bit colour
//   into the colour mapper's priority chain (mario/luigi/goomba/coin each
//   instantiate one). Maps DrawX/DrawY to an address in the sprite's
//   synchronous frame ROM and keys out transparent texels. Latches position,
//   flip and visibility once per frame, and steps a walk-animation counter.
// PARAMETERS
//   SPR_W       16          sprite width in pixels
//   SPR_H       32          sprite height in pixels
//   NUM_FRAMES  4           animation frames stored back-to-back in ROM
//   ANIM_DIV    6           video frames per animation step
//   ADDR_W      11          ROM address width; >= clog2(NUM_FRAMES*SPR_W*SPR_H)
//   TRANSP      24'hFF00FF  colour key treated as transparent
// PORTS
//   Clk          in   1       system clock
//   Reset        in   1       synchronous, active-high reset
//   frame_start  in   1       one-cycle pulse at start of vertical blank
//   DrawX        in   10      current pixel column, 0..639
//   DrawY        in   10      current pixel row, 0..479
//   pos_x        in   10      sprite top-left X (game logic, any time)
//   pos_y        in   10      sprite top-left Y
//   flip         in   1       1 = mirror horizontally (facing left)
//   anim_en      in   1       1 = walking (cycle frames); 0 = frame 0
//   visible      in   1       0 = sprite hidden (dead/collected)
//   rom_addr     out  ADDR_W  address to sprite ROM (ROM read latency = 1)
//   rom_data     in   24      ROM texel {R,G,B}, valid one cycle after rom_addr
//   sprite_on    out  1       pixel belongs to sprite and is not transparent
//   pic_out      out  24      texel colour; 24'h0 when sprite_on = 0
//   anim_frame   out  clog2(NUM_FRAMES)  current animation frame index
// BEHAVIOUR
//   Reset: rom_addr=0, sprite_on=0, pic_out=0, anim_frame=0; latched
//     pos/flip=0, visible=0, divider=0, all pipeline valid bits=0.
//   Shadow regs: on Clk edge with frame_start=1, latch pos_x/pos_y/flip/visible.
//     Pixels sampled on that same edge use the previous latched values.
//   Stage 1 (edge k): in_box = DrawX>=px && DrawX<px+SPR_W && DrawY>=py &&
//     DrawY<py+SPR_H, all compares in 11 bits (no wrap at 639/479).
//     lx = flip ? SPR_W-1-(DrawX-px) : DrawX-px;  ly = DrawY-py.
//     rom_addr <= anim_frame*SPR_W*SPR_H + ly*SPR_W + lx if in_box, else 0.
//     v1 <= in_box & visible_latched.
//   Stage 2: ROM registers rom_addr at edge k+1; v2 <= v1.
//   Output (edge k+2): sprite_on <= v2 && (rom_data != TRANSP);
//     pic_out <= sprite_on-next ? rom_data : 24'h0.
//   Latency: exactly 2 Clk cycles from DrawX/DrawY sample to output; top level
//     delays hs/vs/blank by 2 to match. Throughput 1 pixel/cycle, no stalls.
//   Animation (updates only on frame_start edges):
//     anim_en=0: divider<=0, anim_frame<=0.
//     anim_en=1: divider==ANIM_DIV-1 -> divider<=0 and anim_frame<=
//       (anim_frame==NUM_FRAMES-1 ? 0 : anim_frame+1); else divider+1.
//     anim_frame change applies to pixels sampled after that edge.
//   Edge cases: sprite partly beyond X=639/Y=479 clipped by in_box only;
//     pos at 0 valid; frame_start during active video allowed (mid-frame
//     latch, tearing accepted). Reset mid-frame: outputs 0 from the next edge;
//     sprite stays hidden until a frame_start latches visible=1.
// TESTING
//   1 Reset, frame_start with pos=(100,200), visible=1, flip=0; scan X=100,Y=200
//     -> rom_addr=0 one cycle later; sprite_on/pic_out = rom[0] two cycles later.
//   2 Same, flip=1, DrawX=100,DrawY=201 -> rom_addr=31 (row 1, lx=15).
//   3 rom_data=24'hFF00FF inside box -> sprite_on=0, pic_out=0; DrawX=116 -> in_box=0.
//   4 anim_en=1, 6 frame_start pulses -> anim_frame 0->1; 24 pulses -> wraps to 0;
//     anim_en=0 on next pulse -> anim_frame=0, divider=0.
//   5 Change pos_x mid-frame without frame_start -> addresses unchanged until
//     next frame_start; pos_x=630 -> columns 640+ never asserted.
//   6 Assert Reset mid-scanline inside box -> sprite_on=0 next edge; stays 0
//     until frame_start with visible=1.

Source files
------------

// File: rtl/sprite_pixel_gen.sv
// Per-sprite pixel source: maps DrawX/DrawY into a synchronous frame ROM,
// keys out transparent texels and steps a walk-animation frame counter.
`timescale 1ns/1ps
module sprite_pixel_gen #(
    parameter int          SPR_W      = 16,
    parameter int          SPR_H      = 32,
    parameter int          NUM_FRAMES = 4,
    parameter int          ANIM_DIV   = 6,
    parameter int          ADDR_W     = 11,
    parameter logic [23:0] TRANSP     = 24'hFF00FF,
    localparam int         FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int         DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip,
    input  logic              anim_en,
    input  logic              visible,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sprite_on,
    output logic [23:0]       pic_out,
    output logic [FW-1:0]     anim_frame
);

    logic [9:0]        px, py;
    logic              flip_l, vis_l;
    logic [DW-1:0]     div_q;
    logic [FW-1:0]     frame_q;
    logic              v1, v2;
    logic              in_box;
    logic              hit;
    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_d;

    // Shadow registers and animation step only move at frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            px      <= '0;
            py      <= '0;
            flip_l  <= 1'b0;
            vis_l   <= 1'b0;
            div_q   <= '0;
            frame_q <= '0;
        end else if (frame_start) begin
            px     <= pos_x;
            py     <= pos_y;
            flip_l <= flip;
            vis_l  <= visible;
            if (!anim_en) begin
                div_q   <= '0;
                frame_q <= '0;
            end else if (div_q == DW'(ANIM_DIV - 1)) begin
                div_q   <= '0;
                frame_q <= (frame_q == FW'(NUM_FRAMES - 1)) ? '0
                                                            : frame_q + FW'(1);
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    // 11-bit compares so a sprite near the right/bottom edge never wraps.
    always_comb begin
        in_box = ({1'b0, DrawX} >= {1'b0, px}) &&
                 ({1'b0, DrawX} <  {1'b0, px} + 11'(SPR_W)) &&
                 ({1'b0, DrawY} >= {1'b0, py}) &&
                 ({1'b0, DrawY} <  {1'b0, py} + 11'(SPR_H));
        dx     = DrawX - px;
        dy     = DrawY - py;
        col    = flip_l ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx) : ADDR_W'(dx);
        addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H) +
                 ADDR_W'(dy) * ADDR_W'(SPR_W) + col;
        hit    = v2 && (rom_data != TRANSP);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sprite_on <= 1'b0;
            pic_out   <= '0;
        end else begin
            rom_addr  <= in_box ? addr_d : '0;
            v1        <= in_box & vis_l;
            v2        <= v1;
            sprite_on <= hit;
            pic_out   <= hit ? rom_data : '0;
        end
    end

    assign anim_frame = frame_q;

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Bench for sprite_pixel_gen: frame-level model plus directed pixel probes.
`timescale 1ns/1ps
module tb_sprite_pixel_gen;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        flip, anim_en, visible;
    logic [10:0] rom_addr;
    logic [23:0] rom_data;
    logic        sprite_on;
    logic [23:0] pic_out;
    logic [1:0]  anim_frame;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    localparam logic [23:0] KEY = 24'hFF00FF;

    sprite_pixel_gen dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
        .flip(flip), .anim_en(anim_en), .visible(visible),
        .rom_addr(rom_addr), .rom_data(rom_data), .sprite_on(sprite_on),
        .pic_out(pic_out), .anim_frame(anim_frame)
    );

    always #5 Clk = ~Clk;

    // ROM image: every texel whose address ends in 3'b101 is the colour key.
    function automatic logic [23:0] rom_fn(input logic [10:0] a);
        logic [2:0] lo;
        lo = a[2:0];
        return (lo == 3'd5) ? KEY : {a, 13'h00AB};
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    // Model state: what was latched at the last frame_start, and the
    // number of consecutive walking frame_starts since the last stop.
    int m_px, m_py, m_cnt;
    bit m_flip, m_vis;
    int e_addr;
    logic [24:0] e1, e2, e3;

    function automatic int m_frame();
        return (m_cnt / 6) % 4;
    endfunction

    function automatic bit m_inbox(int x, int y);
        return x >= m_px && x < m_px + 16 && y >= m_py && y < m_py + 32;
    endfunction

    function automatic int m_addr(int x, int y);
        int lx;
        lx = m_flip ? 15 - (x - m_px) : x - m_px;
        return (m_frame() * 512 + (y - m_py) * 16 + lx) % 2048;
    endfunction

    function automatic logic [24:0] m_pix(int x, int y);
        logic [23:0] t;
        if (!(m_vis && m_inbox(x, y))) return '0;
        t = rom_fn(11'(m_addr(x, y)));
        return (t == KEY) ? 25'd0 : {1'b1, t};
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_px <= 0; m_py <= 0; m_cnt <= 0;
            m_flip <= 1'b0; m_vis <= 1'b0;
            e_addr <= 0; e1 <= '0; e2 <= '0; e3 <= '0;
        end else begin
            e_addr <= m_inbox(int'(DrawX), int'(DrawY)) ?
                      m_addr(int'(DrawX), int'(DrawY)) : 0;
            e1 <= m_pix(int'(DrawX), int'(DrawY));
            e2 <= e1;
            e3 <= e2;
            if (frame_start) begin
                m_px <= int'(pos_x);
                m_py <= int'(pos_y);
                m_flip <= flip;
                m_vis <= visible;
                m_cnt <= anim_en ? m_cnt + 1 : 0;
            end
        end
    end

    task automatic chk(input string n, input int act, input int expv);
        total = total + 1;
        if (act != expv) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h exp=%0h at %0t", n, act, expv, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_rom_addr", int'(rom_addr), e_addr);
            chk("m_sprite_on", int'(sprite_on), int'(e3[24]));
            chk("m_pic_out", int'(pic_out), int'(e3[23:0]));
            chk("m_anim_frame", int'(anim_frame), m_frame());
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic fpulse();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic probe(input int x, input int y,
                         output int a, output int on, output int pic);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        a = int'(rom_addr);
        DrawX = '0;
        DrawY = '0;
        tick();
        tick();
        on  = int'(sprite_on);
        pic = int'(pic_out);
    endtask

    int a, on, pic;

    initial begin
        Reset = 1'b1; frame_start = 1'b0;
        DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0;
        flip = 1'b0; anim_en = 1'b0; visible = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_on", int'(sprite_on), 0);
        chk("rst_pic", int'(pic_out), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_frame", int'(anim_frame), 0);
        Reset = 1'b0;

        pos_x = 10'd100; pos_y = 10'd200; visible = 1'b1;
        fpulse();
        probe(100, 200, a, on, pic);
        chk("t1_addr", a, 0);
        chk("t1_on", on, 1);
        chk("t1_pic", pic, 24'h0000AB);

        flip = 1'b1;
        fpulse();
        probe(100, 201, a, on, pic);
        chk("t2_addr", a, 31);
        chk("t2_pic", pic, 24'h03E0AB);

        flip = 1'b0;
        fpulse();
        probe(105, 200, a, on, pic);
        chk("t3_key_addr", a, 5);
        chk("t3_key_on", on, 0);
        chk("t3_key_pic", pic, 0);
        probe(116, 200, a, on, pic);
        chk("t3_x116_addr", a, 0);
        chk("t3_x116_on", on, 0);
        probe(115, 231, a, on, pic);
        chk("t3_corner_addr", a, 511);
        chk("t3_corner_on", on, 1);

        anim_en = 1'b1;
        repeat (6) fpulse();
        chk("t4_frame6", int'(anim_frame), 1);
        probe(100, 200, a, on, pic);
        chk("t4_frame1_addr", a, 512);
        repeat (6) fpulse();
        chk("t4_frame12", int'(anim_frame), 2);
        repeat (12) fpulse();
        chk("t4_wrap24", int'(anim_frame), 0);
        repeat (3) fpulse();
        anim_en = 1'b0;
        fpulse();
        chk("t4_stop", int'(anim_frame), 0);
        anim_en = 1'b1;
        repeat (5) fpulse();
        chk("t4_div_clr", int'(anim_frame), 0);
        fpulse();
        chk("t4_div_step", int'(anim_frame), 1);
        anim_en = 1'b0;
        fpulse();

        pos_x = 10'd300;
        probe(100, 200, a, on, pic);
        chk("t5_hold_addr", a, 0);
        chk("t5_hold_on", on, 1);
        fpulse();
        probe(300, 200, a, on, pic);
        chk("t5_new_addr", a, 0);
        pos_x = 10'd630;
        fpulse();
        probe(639, 200, a, on, pic);
        chk("t5_edge_addr", a, 9);
        chk("t5_edge_on", on, 1);
        probe(5, 200, a, on, pic);
        chk("t5_wrap_on", on, 0);

        visible = 1'b0;
        fpulse();
        probe(639, 200, a, on, pic);
        chk("hid_addr", a, 9);
        chk("hid_on", on, 0);

        pos_x = 10'd100; visible = 1'b1;
        fpulse();
        DrawX = 10'd101; DrawY = 10'd202;
        tick(); tick(); tick();
        chk("t6_pre_on", int'(sprite_on), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_rst_on", int'(sprite_on), 0);
        chk("t6_rst_pic", int'(pic_out), 0);
        tick(); tick(); tick();
        chk("t6_hidden_on", int'(sprite_on), 0);
        fpulse();
        probe(101, 202, a, on, pic);
        chk("t6_back_addr", a, 33);
        chk("t6_back_on", on, 1);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
